// File: rtl/transform_reorder.sv
// Bit-reversal reorder buffer: two-bank ping-pong memory, bit-reversed frames in, natural order out.
// Optional macro TRANSFORM_REORDER_FFTSHIFT_EN reads out in DC-centred (fftshift) order instead.
module transform_reorder #(
    parameter int WIDTH = 16,
    parameter int N     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2*WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_last
);

    localparam int DW    = 2 * WIDTH;
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid never waits on ready, and m_data/m_last hold while m_valid & !m_ready.

    logic [DW-1:0]    r_mem [0:1][0:N-1];
    logic [1:0]       r_full;
    logic             r_wsel;
    logic             r_rsel;
    logic [LOG2N-1:0] r_wcnt;
    logic [LOG2N-1:0] r_rcnt;
    logic             r_m_valid;
    logic             r_m_last;
    logic [DW-1:0]    r_m_data;

    logic             w_wr;
    logic             w_ld;
    logic [LOG2N-1:0] w_waddr;
    logic [LOG2N-1:0] w_raddr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] b;
        b = '0;
        for (int i = 0; i < LOG2N; i++) begin
            b[i] = a[LOG2N-1-i];
        end
        return b;
    endfunction

    assign s_ready = reset_n & ~r_full[r_wsel];
    assign w_wr    = s_valid & s_ready;
    assign w_ld    = (~r_m_valid | m_ready) & r_full[r_rsel];
    assign w_waddr = bitrev(r_wcnt);

`ifdef TRANSFORM_REORDER_FFTSHIFT_EN
    assign w_raddr = r_rcnt ^ LOG2N'(N / 2);
`else
    assign w_raddr = r_rcnt;
`endif

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wsel][w_waddr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full    <= '0;
            r_wsel    <= 1'b0;
            r_rsel    <= 1'b0;
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + ONE;
                if (r_wcnt == LAST_IDX) begin
                    r_full[r_wsel] <= 1'b1;
                    r_wsel         <= ~r_wsel;
                end
            end
            // Set and clear below always hit different banks, so their order here is irrelevant.
            if (w_ld) begin
                r_m_data  <= r_mem[r_rsel][w_raddr];
                r_m_valid <= 1'b1;
                r_m_last  <= (r_rcnt == LAST_IDX);
                r_rcnt    <= r_rcnt + ONE;
                if (r_rcnt == LAST_IDX) begin
                    r_full[r_rsel] <= 1'b0;
                    r_rsel         <= ~r_rsel;
                end
            end else if (m_ready && r_m_valid) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_data  = r_m_data;

endmodule

// File: tb/tb_transform_reorder.sv
// Directed bench for transform_reorder (N=16, WIDTH=16): expected-queue scoreboard on the output side.
module tb_transform_reorder;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int DW = 2 * W;

    logic          clk;
    logic          reset_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    int checks;
    int errors;
    int cyc;
    int rdy_mode;
    int stall_cnt;
    int out_cnt;
    int first_cyc;
    int last_cyc;

    logic [DW:0] exp_q[$];

`ifdef TRANSFORM_REORDER_FFTSHIFT_EN
    int order[16] = '{1, 9, 5, 13, 3, 11, 7, 15, 0, 8, 4, 12, 2, 10, 6, 14};
`else
    int order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`endif

    transform_reorder #(.WIDTH(W), .N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int f, input int k);
        return {W'(f * 16 + k), W'(k)};
    endfunction

    // downstream ready driver: 0 = low, 1 = high, 2 = random
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(1, 0) == 1);
        end
    end

    // output monitor / scoreboard
    logic          hold;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [DW:0]   e;

    initial hold = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (hold) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", 64'(m_data), 64'(hold_data));
                check("hold_last", 64'(m_last), 64'(hold_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_expected", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(m_data), 64'(e[DW-1:0]));
                    check("out_last", 64'(m_last), 64'(e[DW]));
                    if (out_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    out_cnt++;
                end
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end else begin
            hold = 1'b0;
        end
    end

    // driver tasks (caller is always aligned at posedge+1)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [DW-1:0] d, input int budget, output bit ok);
        s_data  = d;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else stall_cnt++;
            step();
        end
    endtask

    task automatic send_frame(input int f, input int gap_max);
        bit ok;
        for (int k = 0; k < 16; k++) begin
            if (gap_max > 0 && $urandom_range(2, 0) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(gap_max, 1)) step();
            end
            send_sample(mk(f, k), 200, ok);
            check("accept", 64'(ok), 64'(1));
        end
        for (int j = 0; j < 16; j++) begin
            exp_q.push_back({(j == 15), mk(f, order[j])});
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) step();
        repeat (2) step();
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bit ok;
        checks    = 0;
        errors    = 0;
        stall_cnt = 0;
        out_cnt   = 0;
        first_cyc = 0;
        last_cyc  = 0;
        rdy_mode  = 1;
        reset_n   = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;

        repeat (3) step();
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_rst_s_ready", 64'(s_ready), 64'(1));

        // single frame: latency and order
        out_cnt = 0;
        send_frame(0, 0);
        check("lat_before", 64'(m_valid), 64'(0));
        s_valid = 1'b0;
        step();
        check("lat_first", 64'(m_valid), 64'(1));
        wait_drain("drain_t1", 100);
        check("cnt_t1", 64'(out_cnt), 64'(16));

        // three back-to-back frames at full rate
        out_cnt   = 0;
        stall_cnt = 0;
        for (int f = 1; f <= 3; f++) send_frame(f, 0);
        s_valid = 1'b0;
        wait_drain("drain_t2", 200);
        check("cnt_t2", 64'(out_cnt), 64'(48));
        check("gapless_t2", 64'(last_cyc - first_cyc), 64'(47));
        check("stall_t2", 64'(stall_cnt), 64'(0));

        // backpressure: both banks fill, then drain
        rdy_mode = 0;
        repeat (2) step();
        out_cnt = 0;
        send_frame(0, 0);
        send_frame(1, 0);
        send_sample(mk(2, 0), 20, ok);
        check("full_block", 64'(ok), 64'(0));
        s_valid = 1'b0;
        check("full_s_ready", 64'(s_ready), 64'(0));
        check("full_m_valid", 64'(m_valid), 64'(1));
        check("full_m_data", 64'(m_data), 64'(0));
        check("cnt_held", 64'(out_cnt), 64'(0));
        rdy_mode = 1;
        wait_drain("drain_t3", 200);
        check("cnt_t3", 64'(out_cnt), 64'(32));

        // random ready and input gaps
        rdy_mode = 2;
        out_cnt  = 0;
        for (int f = 0; f < 8; f++) send_frame(f + 8, 2);
        s_valid = 1'b0;
        wait_drain("drain_t4", 2000);
        check("cnt_t4", 64'(out_cnt), 64'(128));
        rdy_mode = 1;
        repeat (2) step();

        // asynchronous reset mid-frame
        for (int k = 0; k < 7; k++) begin
            send_sample(mk(20, k), 50, ok);
            check("pre_rst_accept", 64'(ok), 64'(1));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'(0));
        check("arst_m_data", 64'(m_data), 64'(0));
        check("arst_m_last", 64'(m_last), 64'(0));
        check("arst_s_ready", 64'(s_ready), 64'(0));
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        step();
        check("rel_s_ready", 64'(s_ready), 64'(1));
        out_cnt = 0;
        send_frame(21, 0);
        s_valid = 1'b0;
        wait_drain("drain_t5", 100);
        check("cnt_t5", 64'(out_cnt), 64'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
